// File: rtl/fp32_dot_acc_if.sv
// Stream handshake bundle for fp32_dot_accumulator: product input
// and dot-product result output, each with its own valid/ready pair.
interface fp32_dot_acc_if #(
   parameter int CNT_W = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [31:0]      in_data;
   logic             in_last;
   logic             out_valid;
   logic             out_ready;
   logic [31:0]      out_data;
   logic [CNT_W-1:0] out_count;
   logic             out_overflow;

   modport master (
      output in_valid, in_data, in_last, out_ready,
      input  in_ready, out_valid, out_data, out_count, out_overflow
   );

   modport slave (
      input  in_valid, in_data, in_last, out_ready,
      output in_ready, out_valid, out_data, out_count, out_overflow
   );
endinterface

// File: rtl/fp32_dot_accumulator.sv
// Multi-cycle fp32 running-sum accumulator (align/add/norm/round FSM).
// FP_ACC_RNE_EN selects round-to-nearest-even; otherwise truncation.
module fp32_dot_accumulator #(
   parameter int CNT_W = 16
) (
   input  logic          clk,
   input  logic          rst,
   fp32_dot_acc_if.slave bus
);
   typedef enum logic [2:0] {
      S_IDLE, S_ALIGN, S_ADD, S_NORM, S_ROUND, S_OUT
   } state_t;

   state_t            state_q, state_d;
   logic [31:0]       acc_q, acc_d;
   logic [31:0]       b_q, b_d;
   logic [31:0]       spv_q, spv_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              ovf_q, ovf_d;
   logic              last_q, last_d;
   logic              sgn_q, sgn_d;
   logic              sub_q, sub_d;
   logic              spc_q, spc_d;
   logic              zero_q, zero_d;
   logic signed [9:0] exp_q, exp_d;
   logic [27:0]       man_q, man_d;
   logic [26:0]       sml_q, sml_d;

   logic [7:0]        ea, eb, diff;
   logic [23:0]       ma, mb;
   logic              ia, ib, na, a_big;
   logic [53:0]       shv;
   logic [4:0]        lz;
   logic              found;
   logic [24:0]       rnd;
   logic              inc;
   logic signed [9:0] ex;

   assign bus.in_ready     = (state_q == S_IDLE) && !rst;
   assign bus.out_valid    = (state_q == S_OUT);
   assign bus.out_data     = acc_q;
   assign bus.out_count    = cnt_q;
   assign bus.out_overflow = ovf_q;

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      b_d     = b_q;
      spv_d   = spv_q;
      cnt_d   = cnt_q;
      ovf_d   = ovf_q;
      last_d  = last_q;
      sgn_d   = sgn_q;
      sub_d   = sub_q;
      spc_d   = spc_q;
      zero_d  = zero_q;
      exp_d   = exp_q;
      man_d   = man_q;
      sml_d   = sml_q;
      ea      = acc_q[30:23];
      eb      = b_q[30:23];
      ma      = (ea == 8'd0) ? 24'd0 : {1'b1, acc_q[22:0]};
      mb      = (eb == 8'd0) ? 24'd0 : {1'b1, b_q[22:0]};
      ia      = (ea == 8'hFF);
      ib      = (eb == 8'hFF);
      na      = ia && (acc_q[22:0] != 23'd0);
      a_big   = ({ea, ma} >= {eb, mb});
      diff    = a_big ? (ea - eb) : (eb - ea);
      shv     = '0;
      lz      = '0;
      found   = 1'b0;
      rnd     = '0;
      inc     = 1'b0;
      ex      = '0;
      unique case (state_q)
         S_IDLE: begin
            if (bus.in_valid) begin
               b_d    = bus.in_data;
               last_d = bus.in_last;
               if (~&cnt_q) cnt_d = cnt_q + 1'b1;
               state_d = S_ALIGN;
            end
         end
         S_ALIGN: begin
            spc_d = ia || ib;
            if (na) spv_d = acc_q;
            else if (ia && ib && (acc_q[31] != b_q[31])) spv_d = 32'h7FC0_0000;
            else if (ia) spv_d = {acc_q[31], 8'hFF, 23'd0};
            else spv_d = {b_q[31], 8'hFF, 23'd0};
            sgn_d = a_big ? acc_q[31] : b_q[31];
            sub_d = acc_q[31] ^ b_q[31];
            exp_d = {2'b00, (a_big ? ea : eb)};
            man_d = {1'b0, (a_big ? ma : mb), 3'b000};
            // Lower 27 bits of shv collect everything shifted past sticky
            shv = {(a_big ? mb : ma), 3'b000, 27'd0} >> diff;
            if (diff >= 8'd27) sml_d = {26'd0, |(a_big ? mb : ma)};
            else sml_d = {shv[53:28], shv[27] | (|shv[26:0])};
            state_d = S_ADD;
         end
         S_ADD: begin
            man_d = sub_q ? (man_q - {1'b0, sml_q}) : (man_q + {1'b0, sml_q});
            state_d = S_NORM;
         end
         S_NORM: begin
            zero_d = 1'b0;
            if (man_q[27]) begin
               man_d = {1'b0, man_q[27:2], man_q[1] | man_q[0]};
               exp_d = exp_q + 10'sd1;
            end else if (man_q == 28'd0) begin
               zero_d = 1'b1;
               sgn_d  = 1'b0;
            end else begin
               for (int i = 26; i >= 0; i--) begin
                  if (!found && man_q[i]) begin
                     found = 1'b1;
                     lz    = 5'(26 - i);
                  end
               end
               man_d  = man_q << lz;
               ex     = exp_q - $signed({5'd0, lz});
               exp_d  = ex;
               zero_d = (ex <= 10'sd0);
            end
            state_d = S_ROUND;
         end
         S_ROUND: begin
`ifdef FP_ACC_RNE_EN
            inc = man_q[2] & (man_q[1] | man_q[0] | man_q[3]);
`else
            inc = 1'b0;
`endif
            rnd = {1'b0, man_q[26:3]} + {24'd0, inc};
            ex  = rnd[24] ? (exp_q + 10'sd1) : exp_q;
            if (spc_q) begin
               acc_d = spv_q;
               ovf_d = ovf_q | (&spv_q[30:23]);
            end else if (zero_q) begin
               acc_d = {sgn_q, 31'd0};
            end else if (ex >= 10'sd255) begin
               acc_d = {sgn_q, 8'hFF, 23'd0};
               ovf_d = 1'b1;
            end else begin
               acc_d = {sgn_q, ex[7:0], (rnd[24] ? rnd[23:1] : rnd[22:0])};
            end
            state_d = last_q ? S_OUT : S_IDLE;
         end
         S_OUT: begin
            if (bus.out_ready) begin
               acc_d   = '0;
               cnt_d   = '0;
               ovf_d   = 1'b0;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         acc_q   <= '0;
         b_q     <= '0;
         spv_q   <= '0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
         last_q  <= 1'b0;
         sgn_q   <= 1'b0;
         sub_q   <= 1'b0;
         spc_q   <= 1'b0;
         zero_q  <= 1'b0;
         exp_q   <= '0;
         man_q   <= '0;
         sml_q   <= '0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         b_q     <= b_d;
         spv_q   <= spv_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
         last_q  <= last_d;
         sgn_q   <= sgn_d;
         sub_q   <= sub_d;
         spc_q   <= spc_d;
         zero_q  <= zero_d;
         exp_q   <= exp_d;
         man_q   <= man_d;
         sml_q   <= sml_d;
      end
   end
endmodule

// File: tb/tb_fp32_dot_accumulator.sv
// Bench for fp32_dot_accumulator: directed vector table, corner
// sequences, and random dot products against an exact-integer model.
module tb_fp32_dot_accumulator;
   localparam int CW = 4;

   logic clk;
   logic rst;
   int   n_chk;
   int   n_pass;

   fp32_dot_acc_if #(.CNT_W(CW)) bus ();

   fp32_dot_accumulator #(.CNT_W(CW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] t0;
      logic [31:0] t1;
      int          n;
      logic [31:0] ed;
      int          ec;
      logic        eo;
   } vec_t;

   vec_t tbl[8];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   // Value of an in-window term in units of 2^-30 (exponents 120..255 only)
   function automatic longint to_int(input logic [31:0] f);
      longint m;
      m = longint'({1'b1, f[22:0]}) <<< (int'(f[30:23]) - 120);
      return f[31] ? -m : m;
   endfunction

   // Round an exact sum (units of 2^-30) to fp32; r gets the rounded value
   function automatic logic [31:0] fp_round(input longint s, output longint r);
      longint mag, q, rem, half;
      int     p, sh, e;
      logic   neg;
      if (s == 0) begin
         r = 0;
         return 32'h0;
      end
      neg = (s < 0);
      mag = neg ? -s : s;
      p   = -1;
      for (int i = 62; i >= 0; i--) if (mag[i] && p < 0) p = i;
      if (p > 23) begin
         sh   = p - 23;
         q    = mag >>> sh;
         rem  = mag - (q <<< sh);
         half = longint'(1) <<< (sh - 1);
`ifdef FP_ACC_RNE_EN
         if (rem > half || (rem == half && q[0])) q = q + 1;
`endif
         if (q == (longint'(1) <<< 24)) begin
            q  = q >>> 1;
            sh = sh + 1;
         end
         r = q <<< sh;
         e = sh + 23 + 97;
      end else begin
         q = mag <<< (23 - p);
         r = mag;
         e = p + 97;
      end
      if (neg) r = -r;
      return {neg, 8'(e), q[22:0]};
   endfunction

   task automatic put(input logic [31:0] d, input logic l);
      int w;
      w = 0;
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      bus.in_last  = l;
      while (!bus.in_ready && w < 40) begin
         @(negedge clk);
         w++;
      end
      if (!bus.in_ready) begin
         n_chk++;
         $display("FAIL accept_timeout: got in_ready 0 expected 1");
      end
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_out(output int cyc);
      cyc = 1;
      while (!bus.out_valid && cyc < 60) begin
         @(negedge clk);
         cyc++;
      end
   endtask

   task automatic get(input string nm, input logic [31:0] ed, input int ec,
                      input logic eo, input int elat);
      int cyc;
      wait_out(cyc);
      chk({nm, "/valid"}, bus.out_valid, 1);
      if (elat > 0) chk({nm, "/latency"}, cyc, elat);
      chk({nm, "/data"}, bus.out_data, ed);
      chk({nm, "/count"}, bus.out_count, ec);
      chk({nm, "/ovf"}, bus.out_overflow, eo);
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
   endtask

   initial begin
      int          cyc;
      int          n;
      bit          ok;
      logic [31:0] t, bits;
      longint      macc, s;

      n_chk = 0;
      n_pass = 0;
      rst = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.in_last   = 1'b0;
      bus.out_ready = 1'b0;

      tbl[0] = '{32'h3F800000, 32'h40000000, 2, 32'h40400000, 2, 1'b0};
      tbl[1] = '{32'h3FC00000, 32'hBFC00000, 2, 32'h00000000, 2, 1'b0};
      tbl[2] = '{32'h7F7FFFFF, 32'h7F7FFFFF, 2, 32'h7F800000, 2, 1'b1};
`ifdef FP_ACC_RNE_EN
      tbl[3] = '{32'h3F800001, 32'h33800000, 2, 32'h3F800002, 2, 1'b0};
`else
      tbl[3] = '{32'h3F800001, 32'h33800000, 2, 32'h3F800001, 2, 1'b0};
`endif
      tbl[4] = '{32'h7F800000, 32'hFF800000, 2, 32'h7FC00000, 2, 1'b1};
      tbl[5] = '{32'h3F800000, 32'h00000001, 2, 32'h3F800000, 2, 1'b0};
      tbl[6] = '{32'h40A00000, 32'h0,        1, 32'h40A00000, 1, 1'b0};
      tbl[7] = '{32'hFF800000, 32'h3F800000, 2, 32'hFF800000, 2, 1'b1};

      repeat (2) @(negedge clk);
      chk("rst/in_ready", bus.in_ready, 0);
      chk("rst/out_valid", bus.out_valid, 0);
      chk("rst/out_data", bus.out_data, 0);
      chk("rst/out_count", bus.out_count, 0);
      chk("rst/out_ovf", bus.out_overflow, 0);
      rst = 1'b0;
      #1;
      chk("rst/in_ready_after", bus.in_ready, 1);
      @(negedge clk);

      for (int i = 0; i < 8; i++) begin
         put(tbl[i].t0, tbl[i].n == 1);
         if (tbl[i].n == 2) put(tbl[i].t1, 1'b1);
         get($sformatf("vec%0d", i), tbl[i].ed, tbl[i].ec, tbl[i].eo, 5);
      end

      // Result held while consumer stalls; producer keeps offering a term
      put(32'h3F800000, 1'b1);
      wait_out(cyc);
      bus.in_valid = 1'b1;
      bus.in_data  = 32'h41000000;
      bus.in_last  = 1'b1;
      ok = 1'b1;
      repeat (10) begin
         @(negedge clk);
         if (!bus.out_valid || bus.out_data !== 32'h3F800000 || bus.in_ready) ok = 1'b0;
      end
      chk("hold/stable", ok, 1);
      chk("hold/count", bus.out_count, 1);
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      chk("hold/released_valid", bus.out_valid, 0);
      chk("hold/released_ready", bus.in_ready, 1);
      put(32'h41000000, 1'b1);
      get("after_hold", 32'h41000000, 1, 1'b0, 5);

      // Reset lands while the third term is in ADD
      put(32'h3F800000, 1'b0);
      put(32'h40000000, 1'b0);
      put(32'h40400000, 1'b1);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("midrst/out_valid", bus.out_valid, 0);
      chk("midrst/out_count", bus.out_count, 0);
      chk("midrst/out_data", bus.out_data, 0);
      rst = 1'b0;
      #1;
      chk("midrst/in_ready", bus.in_ready, 1);
      @(negedge clk);
      put(32'h40A00000, 1'b1);
      get("midrst_fresh", 32'h40A00000, 1, 1'b0, 5);

      // Term counter saturates while the sum keeps growing
      for (int k = 0; k < 20; k++) put(32'h3F800000, k == 19);
      get("saturate", 32'h41A00000, (1 << CW) - 1, 1'b0, 5);

      for (int r = 0; r < 25; r++) begin
         n = $urandom_range(1, 4);
         macc = 0;
         bits = 32'h0;
         for (int k = 0; k < n; k++) begin
            t = {1'($urandom_range(0, 1)), 8'(120 + $urandom_range(0, 14)), 23'($urandom)};
            s = macc + to_int(t);
            bits = fp_round(s, macc);
            put(t, k == n - 1);
         end
         get($sformatf("rnd%0d", r), bits, n, 1'b0, 5);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/fp32_dot_accumulator.md
# fp32_dot_accumulator

Sequential IEEE-754 single-precision accumulator directly downstream of the combinational fp32 multiplier. It consumes a stream of products over a valid/ready handshake and sums them into a running fp32 accumulator. On the term flagged `in_last` it presents the dot-product result and term count on an output handshake. It processes one term every five cycles through an explicit align/add/normalize/round FSM.

## Interface
- `CNT_W`, default 16: width of the accepted-term counter.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: `in_data` / `in_last` valid.
- `in_ready` out 1: block can accept a term.
- `in_data` in 32: fp32 product from the multiplier.
- `in_last` in 1: final term of the current dot product.
- `out_valid` out 1: result valid, held until accepted.
- `out_ready` in 1: consumer accepts result.
- `out_data` out 32: accumulated fp32 sum.
- `out_count` out CNT_W: terms accepted in this dot product, saturating at all-ones.
- `out_overflow` out 1: sum reached ±infinity or NaN during this dot product.

## Operation
- FSM states: IDLE, ALIGN, ADD, NORM, ROUND, OUT.
- `in_ready` = (state==IDLE). A transfer is `in_valid && in_ready`. It latches operand B = `in_data` and the last flag, increments count, and moves to ALIGN.
- Operand decode:
  - exponent 0x00 → zero (subnormals flushed).
  - exponent 0xFF → infinity of its sign (mantissa ignored).
  - otherwise hidden bit = 1.
- ALIGN:
  - Swap so A has the larger magnitude; the accumulator is operand A when equal.
  - Right-shift the smaller 24-bit mantissa into a 27-bit field (24 + guard, round, sticky), ORing shifted-out bits into sticky.
  - Shift ≥ 27 → field = sticky only.
- ADD: 28-bit add if signs match, else subtract smaller from larger. Result sign = sign of the larger operand.
- NORM:
  - Carry out → shift right 1 (sticky preserved), exp+1.
  - Otherwise left-shift by leading-zero count (single-cycle priority encoder), exp−lzc.
  - Exact zero → +0 (0x00000000).
  - Exp ≤ 0 → signed zero.
- ROUND:
  - Apply rounding; mantissa carry renormalizes, exp+1.
  - Exp ≥ 255 → ±infinity (0x7F800000 / 0xFF800000) and overflow flag set.
  - Write acc.
  - Next state: OUT if the last flag is set, else IDLE.
- Special operands:
  - inf + finite → inf.
  - +inf + −inf → canonical NaN 0x7FC00000, overflow flag set.
  - NaN accumulator stays NaN.
- OUT:
  - `out_valid`=1; `out_data`/`out_count`/`out_overflow` are stable registers.
  - On `out_ready`: acc←0, count←0, overflow←0, next IDLE.

## Timing
- Reset values:
  - state IDLE.
  - acc, count, overflow 0.
  - `out_valid`=0, `out_data`=0, `out_count`=0, `out_overflow`=0.
  - `in_ready`=0 during the reset cycle, 1 the first cycle after `rst` deasserts.
- Accept at cycle T → ALIGN T+1, ADD T+2, NORM T+3, ROUND T+4. Acc is updated at the end of T+4.
- Next accept is possible at T+5 (throughput 1 term / 5 cycles). If last: `out_valid` is high from T+5.
- `in_ready`=0 throughout ALIGN..OUT. Inputs presented then are ignored and must be held by the producer.
- OUT with `out_ready`=1 in the first OUT cycle: handshake at T+5, IDLE and `in_ready`=1 at T+6.
- `out_ready` low: OUT held indefinitely, outputs unchanged.
- `rst` in any state: returns to IDLE next edge, partial sum discarded, no output produced.
- Count saturates at 2^CNT_W−1; accumulation continues.

## Configuration
- `FP_ACC_RNE_EN` defined: ROUND performs round-to-nearest-even. Increment if G && (R || S || lsb).
- Undefined: ROUND truncates (G/R/S dropped). ROUND state and latency are unchanged.

## Test plan
- Accept 0x3F800000, then 0x40000000 with last; `out_ready`=1 → `out_data`=0x40400000, `out_count`=2, `out_overflow`=0; `out_valid` 5 cycles after the second accept.
- 0x3FC00000 then 0xBFC00000 (last) → 0x00000000, count 2. Then 0x7F7FFFFF ×2 (last) → 0x7F800000, `out_overflow`=1.
- 0x3F800001 then 0x33800000 (last) → 0x3F800002 with `FP_ACC_RNE_EN`, 0x3F800001 without.
- 0x7F800000 then 0xFF800000 (last) → 0x7FC00000, `out_overflow`=1. A subnormal term 0x00000001 added to 0x3F800000 leaves 0x3F800000.
- Hold `out_ready`=0 for 10 cycles in OUT with `in_valid`=1 → `out_valid` and `out_data` stable, `in_ready`=0, no term accepted. Release → accumulator cleared; the next term alone yields its own value.
- Assert `rst` during ADD of a 3-term sequence → next cycle IDLE, `out_valid`=0; a fresh single term 0x40A00000 (last) → 0x40A00000, count 1.
